// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, issues one outstanding imem request
// at a time, applies trap/branch redirects and buffers one instruction for Decode.
module fetch_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_instr,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_SQUASH} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            issued_q, issued_d;
  logic            squash_pend_q, squash_pend_d;
  logic            fv_q, fv_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [31:0]     finstr_q, finstr_d;

  logic            redir;
  logic [XLEN-1:0] tgt_sel;
  logic [XLEN-1:0] redir_target;
  logic            issue_ok;

  assign redir        = trap_valid | redirect_valid;
  assign tgt_sel      = trap_valid ? trap_target : redirect_target;
  assign redir_target = tgt_sel & ~(XLEN'(3));
  assign issue_ok     = !fv_q || fetch_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      req_addr_q    <= '0;
      issued_q      <= 1'b0;
      squash_pend_q <= 1'b0;
      fv_q          <= 1'b0;
      fpc_q         <= '0;
      finstr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      issued_q      <= issued_d;
      squash_pend_q <= squash_pend_d;
      fv_q          <= fv_d;
      fpc_q         <= fpc_d;
      finstr_q      <= finstr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    issued_d      = issued_q;
    squash_pend_d = squash_pend_q;
    fv_d          = fv_q;
    fpc_d         = fpc_q;
    finstr_d      = finstr_q;

    if (fv_q && fetch_ready) fv_d = 1'b0;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_req) begin
          req_addr_d = imem_addr;
          if (imem_ack) begin
            // A redirect seen at any point during this request turns its response stale.
            state_d       = (redir || squash_pend_q) ? S_SQUASH : S_WAIT;
            issued_d      = 1'b0;
            squash_pend_d = 1'b0;
          end else begin
            issued_d = 1'b1;
            if (redir) squash_pend_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          if (!redir) begin
            fv_d     = 1'b1;
            fpc_d    = req_addr_q;
            finstr_d = imem_rsp_data;
            pc_d     = pc_q + XLEN'(INSTR_BYTES);
          end
        end else if (redir) begin
          state_d = S_SQUASH;
        end
      end
      S_SQUASH: if (imem_rsp_valid) state_d = S_REQ;
      default:  state_d = S_BOOT;
    endcase

    if (redir) begin
      pc_d = redir_target;
      fv_d = 1'b0;
    end
  end

  // Once issued, the request is held from req_addr_q until acknowledged.
  always_comb begin
    imem_req  = (state_q == S_REQ) && (issued_q || issue_ok);
    imem_addr = (state_q == S_REQ && !issued_q) ? pc_q : req_addr_q;
  end

  assign fetch_valid = fv_q;
  assign fetch_pc    = fpc_q;
  assign fetch_instr = finstr_q;
  assign pc          = pc_q;

`ifndef SYNTHESIS
  rsp_in_window: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_SQUASH));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a memory model and redirect generator drive
// the DUT, a scoreboard holds the expected instruction stream, a monitor checks it.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        trap_valid, redirect_valid;
  logic [31:0] trap_target, redirect_target;
  logic        imem_req, imem_ack, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, fetch_instr, pc;

  fetch_sequencer dut (
    .clock(clock), .reset(reset),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .pc(pc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] next_push;

  // stimulus knobs
  int          ack_pct, lat_min, lat_max, ready_pct, redir_pm;
  logic [1:0]  force_kind;
  logic [31:0] force_trap_tgt, force_redir_tgt;
  bit          tput_mode;

  // memory model: at most one response in flight
  bit          pend_rsp;
  int          rsp_cnt;
  logic [31:0] rsp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    logic [1:0] kind;
    exp_t       e;
    @(posedge clock);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend_rsp) begin
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rsp_addr);
        pend_rsp       = 1'b0;
      end else rsp_cnt--;
    end
    fetch_ready = ($urandom_range(99) < ready_pct);
    kind        = force_kind;
    force_kind  = 2'd0;
    if (kind != 2'd0) begin
      trap_target     = force_trap_tgt;
      redirect_target = force_redir_tgt;
    end else begin
      trap_target     = $urandom;
      redirect_target = $urandom;
      if ($urandom_range(999) < redir_pm) kind = 2'($urandom_range(3, 1));
    end
    trap_valid     = kind[1];
    redirect_valid = kind[0];
    if (kind != 2'd0) begin
      exp_q.delete();
      next_push = (kind[1] ? trap_target : redirect_target) & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 4) begin
      e.pc    = next_push;
      e.instr = mem_word(next_push);
      exp_q.push_back(e);
      next_push = next_push + 32'd4;
    end
    #1;
    imem_ack = imem_req && ($urandom_range(99) < ack_pct);
    if (imem_ack) begin
      pend_rsp = 1'b1;
      rsp_cnt  = $urandom_range(lat_max, lat_min) - 1;
      rsp_addr = imem_addr;
    end
  endtask

  task automatic wait_req(input string name, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!imem_req && n < bound);
    if (!imem_req) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string name, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!imem_ack && n < bound);
    if (!imem_ack) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, "_fetch_pc"}, fetch_pc, 32'd0);
    check({tag, "_fetch_instr"}, fetch_instr, 32'd0);
    check({tag, "_pc"}, pc, 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clock);
    #1;
    reset          = 1'b1;
    pend_rsp       = 1'b0;
    imem_ack       = 1'b0;
    imem_rsp_valid = 1'b0;
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    exp_q.delete();
    next_push      = 32'h0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // monitor
  bit          prev_pend, prev_fv, prev_rdy, prev_redir;
  logic [31:0] prev_addr, prev_fpc, prev_finstr;
  int          mcyc = 0;
  int          last_load = -1;

  always @(negedge clock) begin
    bit   held;
    exp_t e;
    mcyc++;
    if (reset) begin
      prev_pend  = 1'b0;
      prev_fv    = 1'b0;
      prev_rdy   = 1'b0;
      prev_redir = 1'b0;
      last_load  = -1;
    end else begin
      if (prev_pend) begin
        check("req_hold", 32'(imem_req), 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end else if (imem_req) begin
        check("issue_cond", 32'(!fetch_valid || fetch_ready), 32'd1);
      end
      if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);

      held = prev_fv && !prev_rdy && !prev_redir;
      if (held) begin
        check("buf_hold_valid", 32'(fetch_valid), 32'd1);
        check("buf_hold_pc", fetch_pc, prev_fpc);
        check("buf_hold_instr", fetch_instr, prev_finstr);
      end else if (fetch_valid) begin
        check("pc_after_load", pc, fetch_pc + 32'd4);
        if (tput_mode && last_load >= 0) check("throughput_gap", 32'(mcyc - last_load), 32'd2);
        last_load = mcyc;
      end

      if (fetch_valid && fetch_ready && !trap_valid && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", fetch_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("fetch_pc", fetch_pc, e.pc);
          check("fetch_instr", fetch_instr, e.instr);
          $display("fetch pc=%h instr=%h", fetch_pc, fetch_instr);
        end
      end

      prev_pend   = imem_req && !imem_ack;
      prev_addr   = imem_addr;
      prev_fv     = fetch_valid;
      prev_rdy    = fetch_ready;
      prev_redir  = trap_valid || redirect_valid;
      prev_fpc    = fetch_pc;
      prev_finstr = fetch_instr;
    end
  end

  initial begin
    logic [31:0] a0;
    reset = 1'b1;
    trap_valid = 1'b0; redirect_valid = 1'b0;
    trap_target = '0; redirect_target = '0;
    imem_ack = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    fetch_ready = 1'b0;
    force_kind = 2'd0; force_trap_tgt = '0; force_redir_tgt = '0;
    pend_rsp = 1'b0; rsp_cnt = 0; rsp_addr = '0;
    next_push = 32'h0; tput_mode = 1'b0;
    ack_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100; redir_pm = 0;

    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // single-cycle memory, Decode always ready: 0x0, 0x4, 0x8 ... every 2 cycles
    tput_mode = 1'b1;
    repeat (20) step();
    tput_mode = 1'b0;

    // Decode stalls with a full buffer, then releases it
    ready_pct = 0;
    repeat (10) step();
    check("stall_buf_full", 32'(fetch_valid), 32'd1);
    ready_pct = 100;
    step();
    check("issue_on_ready", 32'(imem_req), 32'd1);

    // redirect while a response is outstanding
    lat_min = 3; lat_max = 3;
    wait_ack("wait_ack_c", 20);
    force_kind = 2'd1; force_redir_tgt = 32'h0000_0103; force_trap_tgt = 32'h0000_0777;
    step();
    wait_req("wait_req_c", 30);
    check("redirect_req_addr", imem_addr, 32'h0000_0100);

    // trap and branch redirect together against a full buffer
    lat_min = 1; lat_max = 1; ready_pct = 0;
    repeat (8) step();
    force_kind = 2'd3; force_trap_tgt = 32'h0000_0080; force_redir_tgt = 32'h0000_0200;
    step();
    step();
    check("trap_prio_pc", pc, 32'h0000_0080);
    check("trap_drops_buf", 32'(fetch_valid), 32'd0);

    // request left unacknowledged for 5 cycles with a redirect in between
    ready_pct = 100; ack_pct = 0;
    wait_req("wait_req_e", 30);
    a0 = imem_addr;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        force_kind = 2'd1; force_redir_tgt = 32'h0000_0300; force_trap_tgt = 32'h0;
      end
      step();
      check("unacked_addr_stable", imem_addr, a0);
    end
    ack_pct = 100;
    step();
    wait_req("wait_req_e2", 30);
    check("post_squash_addr", imem_addr, 32'h0000_0300);

    // sequential fetch wraps past the top of the address space
    force_kind = 2'd1; force_redir_tgt = 32'hFFFF_FFFC; force_trap_tgt = 32'h0;
    step();
    wait_req("wait_req_f", 30);
    check("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
    wait_req("wait_req_f2", 30);
    check("wrap_next_addr", imem_addr, 32'h0000_0000);

    // reset while waiting for a response
    lat_min = 3; lat_max = 3;
    wait_ack("wait_ack_g", 20);
    apply_reset("rst_in_wait");

    // randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      ack_pct   = $urandom_range(100, 30);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      ready_pct = $urandom_range(100, 20);
      redir_pm  = $urandom_range(120, 0);
      repeat (200) step();
    end

    ack_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100; redir_pm = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
